decode: RTL and testbench

- Decode stage, directly downstream of fetch.
- Consumes the IF-stage instruction (InstrVal_IF, Pc_IF, FetchData_IF).
- In the IDM1 cycle it decodes the instruction, drives register-file read addresses, resolves j/jal into a fetch redirect, and detects load-use hazards.
- In ID it holds a pipeline register of decoded control and operands for execute.

---
 rtl/mips_pkg.sv | 79 +++++++
 rtl/decode_ctrl.sv | 122 ++++++++++++
 rtl/dff.sv | 22 ++
 rtl/decode.sv | 166 ++++++++++++++++
 tb/tb_decode.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared decode definitions: opcode/funct values, ALU operation encoding,
// the decoded control bundle and the ID pipeline register layout.
package mips_pkg;

    localparam int unsigned RegBits = 5;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluSlt = 4'd4,
        AluSll = 4'd5,
        AluSrl = 4'd6,
        AluLui = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ImmSign,
        ImmZero,
        ImmLui
    } imm_sel_e;

    typedef enum logic [1:0] {
        DstNone,
        DstRt,
        DstRd,
        DstRa
    } dst_sel_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src_imm;
        logic    branch;
        logic    branch_ne;
        logic    jump_reg;
        logic    link;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic               valid;
        logic [31:0]        pc;
        logic [RegBits-1:0] rs;
        logic [RegBits-1:0] rt;
        logic [RegBits-1:0] dst;
        logic [31:0]        imm;
        logic [4:0]         shamt;
        ctrl_t              ctrl;
        logic               illegal;
    } id_reg_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode/funct decoder.
//   op, funct : instruction fields
//   ctrl      : control bundle (all zero when illegal)
//   illegal   : unsupported op/funct
//   uses_rs   : instruction reads rs (for load-use detection)
//   uses_rt   : instruction reads rt
//   is_jump   : j or jal
//   imm_sel   : immediate extension mode
//   dst_sel   : destination register source
module decode_ctrl
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       uses_rs,
    output logic       uses_rt,
    output logic       is_jump,
    output imm_sel_e   imm_sel,
    output dst_sel_e   dst_sel
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        is_jump = 1'b0;
        imm_sel = ImmSign;
        dst_sel = DstRt;

        unique case (op)
            OpRtype: begin
                uses_rt        = 1'b1;
                dst_sel        = DstRd;
                ctrl.reg_write = 1'b1;
                unique case (funct)
                    FnAdd: ctrl.alu_op = AluAdd;
                    FnSub: ctrl.alu_op = AluSub;
                    FnAnd: ctrl.alu_op = AluAnd;
                    FnOr:  ctrl.alu_op = AluOr;
                    FnSlt: ctrl.alu_op = AluSlt;
                    FnSll: begin
                        ctrl.alu_op = AluSll;
                        uses_rs     = 1'b0;
                    end
                    FnSrl: begin
                        ctrl.alu_op = AluSrl;
                        uses_rs     = 1'b0;
                    end
                    FnJr: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.jump_reg  = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OpLw: begin
                ctrl.reg_write   = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OpSw: begin
                uses_rt          = 1'b1;
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OpBeq, OpBne: begin
                uses_rt        = 1'b1;
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = (op == OpBne);
                ctrl.alu_op    = AluSub;
            end
            OpAddi: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OpSlti: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = AluSlt;
            end
            OpAndi, OpOri: begin
                imm_sel          = ImmZero;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = (op == OpAndi) ? AluAnd : AluOr;
            end
            OpLui: begin
                imm_sel          = ImmLui;
                uses_rs          = 1'b0;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = AluLui;
            end
            OpJ: begin
                is_jump = 1'b1;
                uses_rs = 1'b0;
                dst_sel = DstNone;
            end
            OpJal: begin
                is_jump        = 1'b1;
                uses_rs        = 1'b0;
                dst_sel        = DstRa;
                ctrl.reg_write = 1'b1;
                ctrl.link      = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        // An unsupported encoding must not write, jump or stall anything.
        if (illegal) begin
            ctrl    = '0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
            is_jump = 1'b0;
            dst_sel = DstNone;
        end
    end

endmodule

// File: rtl/dff.sv
// Generic register with synchronous active-high clear.
//   clk   : clock
//   flush : synchronous clear to all zeros
//   d / q : data in / registered data out
module dff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             flush,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk) begin
        if (flush) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/decode.sv
// Decode stage. IDM1 (combinational on the IF instruction): register-file
// read addresses, j/jal redirect, load-use hazard. ID: pipeline register of
// decoded control and operands for execute.
//   clk, flush            : clock, synchronous active-high clear of ID state
//   *_IF                  : fetched instruction (valid, pc, word)
//   BranchTaken_EXM1      : execute redirect, squashes the IF instruction
//   ExtStall              : stall from other stages, holds ID
//   MemRead_EX, DstReg_EX : reserved for a longer load latency, unused
//   *_IDM1                : combinational decode-cycle outputs
//   *_ID                  : registered decode results
module decode
    import mips_pkg::*;
#(
    parameter int unsigned NREG_BITS = 5,
    parameter int unsigned ALUOP_W   = 4
) (
    input  logic                 clk,
    input  logic                 flush,
    input  logic                 InstrVal_IF,
    input  logic [31:0]          Pc_IF,
    input  logic [31:0]          FetchData_IF,
    input  logic                 BranchTaken_EXM1,
    input  logic                 ExtStall,
    input  logic                 MemRead_EX,
    input  logic [NREG_BITS-1:0] DstReg_EX,
    output logic                 Jump_IDM1,
    output logic [25:0]          JumpTgt_IDM1,
    output logic [NREG_BITS-1:0] RsAddr_IDM1,
    output logic [NREG_BITS-1:0] RtAddr_IDM1,
    output logic                 LoadUseStall_IDM1,
    output logic                 InstrVal_ID,
    output logic [31:0]          Pc_ID,
    output logic [NREG_BITS-1:0] Rs_ID,
    output logic [NREG_BITS-1:0] Rt_ID,
    output logic [NREG_BITS-1:0] DstReg_ID,
    output logic [31:0]          Imm_ID,
    output logic [4:0]           Shamt_ID,
    output logic [ALUOP_W-1:0]   AluOp_ID,
    output logic                 RegWrite_ID,
    output logic                 MemRead_ID,
    output logic                 MemWrite_ID,
    output logic                 AluSrcImm_ID,
    output logic                 Branch_ID,
    output logic                 BranchNe_ID,
    output logic                 JumpReg_ID,
    output logic                 Link_ID,
    output logic                 Illegal_ID
);

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [RegBits-1:0] rs;
    logic [RegBits-1:0] rt;
    logic [RegBits-1:0] rd;
    logic [15:0]        imm16;

    ctrl_t    dec_ctrl;
    logic     dec_illegal;
    logic     uses_rs;
    logic     uses_rt;
    logic     is_jump;
    imm_sel_e imm_sel;
    dst_sel_e dst_sel;

    id_reg_t dec;
    id_reg_t id_d;
    id_reg_t id_q;

    logic unused_ex;

    assign op    = FetchData_IF[31:26];
    assign rs    = FetchData_IF[25:21];
    assign rt    = FetchData_IF[20:16];
    assign rd    = FetchData_IF[15:11];
    assign funct = FetchData_IF[5:0];
    assign imm16 = FetchData_IF[15:0];

    assign unused_ex = ^{MemRead_EX, DstReg_EX};

    decode_ctrl u_decode_ctrl (
        .op      (op),
        .funct   (funct),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .is_jump (is_jump),
        .imm_sel (imm_sel),
        .dst_sel (dst_sel)
    );

    assign RsAddr_IDM1  = rs;
    assign RtAddr_IDM1  = rt;
    assign JumpTgt_IDM1 = FetchData_IF[25:0];
    assign Jump_IDM1    = InstrVal_IF & is_jump & ~BranchTaken_EXM1;

    assign LoadUseStall_IDM1 = InstrVal_IF & ~BranchTaken_EXM1 &
                               id_q.valid & id_q.ctrl.mem_read & (id_q.dst != '0) &
                               (((id_q.dst == rs) & uses_rs) | ((id_q.dst == rt) & uses_rt));

    // Decode of the IF instruction; an invalid slot decodes to a bubble.
    always_comb begin
        dec = '0;
        if (InstrVal_IF) begin
            dec.valid   = 1'b1;
            dec.pc      = Pc_IF;
            dec.rs      = rs;
            dec.rt      = rt;
            dec.shamt   = FetchData_IF[10:6];
            dec.ctrl    = dec_ctrl;
            dec.illegal = dec_illegal;
            case (imm_sel)
                ImmZero: dec.imm = {16'h0000, imm16};
                ImmLui:  dec.imm = {imm16, 16'h0000};
                default: dec.imm = {{16{imm16[15]}}, imm16};
            endcase
            case (dst_sel)
                DstRt:   dec.dst = rt;
                DstRd:   dec.dst = rd;
                DstRa:   dec.dst = 5'd31;
                default: dec.dst = '0;
            endcase
            // r0 is hardwired, so writes to it are dropped here.
            if (dec.dst == '0) begin
                dec.ctrl.reg_write = 1'b0;
            end
        end
    end

    always_comb begin
        id_d = dec;
        if (BranchTaken_EXM1 || LoadUseStall_IDM1) begin
            id_d = '0;
        end else if (ExtStall) begin
            id_d = id_q;
        end
    end

    dff #(
        .Width ($bits(id_reg_t))
    ) u_id_reg (
        .clk   (clk),
        .flush (flush),
        .d     (id_d),
        .q     (id_q)
    );

    assign InstrVal_ID  = id_q.valid;
    assign Pc_ID        = id_q.pc;
    assign Rs_ID        = id_q.rs;
    assign Rt_ID        = id_q.rt;
    assign DstReg_ID    = id_q.dst;
    assign Imm_ID       = id_q.imm;
    assign Shamt_ID     = id_q.shamt;
    assign AluOp_ID     = id_q.ctrl.alu_op;
    assign RegWrite_ID  = id_q.ctrl.reg_write;
    assign MemRead_ID   = id_q.ctrl.mem_read;
    assign MemWrite_ID  = id_q.ctrl.mem_write;
    assign AluSrcImm_ID = id_q.ctrl.alu_src_imm;
    assign Branch_ID    = id_q.ctrl.branch;
    assign BranchNe_ID  = id_q.ctrl.branch_ne;
    assign JumpReg_ID   = id_q.ctrl.jump_reg;
    assign Link_ID      = id_q.ctrl.link;
    assign Illegal_ID   = id_q.illegal;

endmodule

// File: tb/tb_decode.sv
module tb_decode;

    logic        clk = 1'b0;
    logic        flush;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        bt;
    logic        es;
    logic        mre;
    logic [4:0]  dre;

    logic        jump;
    logic [25:0] jtgt;
    logic [4:0]  rsa, rta;
    logic        stall;
    logic        v_id;
    logic [31:0] pc_id;
    logic [4:0]  rs_id, rt_id, dst_id;
    logic [31:0] imm_id;
    logic [4:0]  sh_id;
    logic [3:0]  alu_id;
    logic        rw, mr, mw, asi, br, bne, jr, lnk, ill;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode dut (
        .clk               (clk),
        .flush             (flush),
        .InstrVal_IF       (iv),
        .Pc_IF             (pc),
        .FetchData_IF      (ins),
        .BranchTaken_EXM1  (bt),
        .ExtStall          (es),
        .MemRead_EX        (mre),
        .DstReg_EX         (dre),
        .Jump_IDM1         (jump),
        .JumpTgt_IDM1      (jtgt),
        .RsAddr_IDM1       (rsa),
        .RtAddr_IDM1       (rta),
        .LoadUseStall_IDM1 (stall),
        .InstrVal_ID       (v_id),
        .Pc_ID             (pc_id),
        .Rs_ID             (rs_id),
        .Rt_ID             (rt_id),
        .DstReg_ID         (dst_id),
        .Imm_ID            (imm_id),
        .Shamt_ID          (sh_id),
        .AluOp_ID          (alu_id),
        .RegWrite_ID       (rw),
        .MemRead_ID        (mr),
        .MemWrite_ID       (mw),
        .AluSrcImm_ID      (asi),
        .Branch_ID         (br),
        .BranchNe_ID       (bne),
        .JumpReg_ID        (jr),
        .Link_ID           (lnk),
        .Illegal_ID        (ill)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt, dst;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [3:0]  alu;
        logic        rw, mr, mw, asi, br, bne, jr, lnk, ill;
    } exp_t;

    // What ID must hold after loading instruction 'w' fetched at 'a'.
    function automatic exp_t ref_id(input logic [31:0] w, input logic [31:0] a);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        e = '0;
        e.valid = 1'b1;
        e.pc    = a;
        e.rs    = w[25:21];
        e.rt    = w[20:16];
        e.shamt = w[10:6];
        e.imm   = {{16{w[15]}}, w[15:0]};
        e.dst   = w[20:16];
        case (op)
            6'h00: begin
                e.dst = w[15:11];
                e.rw  = 1'b1;
                case (fn)
                    6'h20: e.alu = 4'd0;
                    6'h22: e.alu = 4'd1;
                    6'h24: e.alu = 4'd2;
                    6'h25: e.alu = 4'd3;
                    6'h2A: e.alu = 4'd4;
                    6'h00: e.alu = 4'd5;
                    6'h02: e.alu = 4'd6;
                    6'h08: begin e.rw = 1'b0; e.jr = 1'b1; end
                    default: e.ill = 1'b1;
                endcase
            end
            6'h23: begin e.rw = 1'b1; e.mr = 1'b1; e.asi = 1'b1; end
            6'h2B: begin e.mw = 1'b1; e.asi = 1'b1; end
            6'h04: begin e.br = 1'b1; e.alu = 4'd1; end
            6'h05: begin e.br = 1'b1; e.bne = 1'b1; e.alu = 4'd1; end
            6'h08: begin e.rw = 1'b1; e.asi = 1'b1; end
            6'h0A: begin e.rw = 1'b1; e.asi = 1'b1; e.alu = 4'd4; end
            6'h0C: begin e.rw = 1'b1; e.asi = 1'b1; e.alu = 4'd2; e.imm = {16'h0, w[15:0]}; end
            6'h0D: begin e.rw = 1'b1; e.asi = 1'b1; e.alu = 4'd3; e.imm = {16'h0, w[15:0]}; end
            6'h0F: begin e.rw = 1'b1; e.asi = 1'b1; e.alu = 4'd7; e.imm = {w[15:0], 16'h0}; end
            6'h02: e.dst = 5'd0;
            6'h03: begin e.dst = 5'd31; e.rw = 1'b1; e.lnk = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.rw = 0; e.mr = 0; e.mw = 0; e.asi = 0; e.br = 0; e.bne = 0;
            e.jr = 0; e.lnk = 0; e.alu = 4'd0;
        end
        if (e.dst == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic reads_rs(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        return !(op == 6'h02 || op == 6'h03 || op == 6'h0F ||
                 (op == 6'h00 && (w[5:0] == 6'h00 || w[5:0] == 6'h02)));
    endfunction

    function automatic logic reads_rt(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        return op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05;
    endfunction

    function automatic logic ref_stall(input exp_t m, input logic v, input logic [31:0] w,
                                       input logic b);
        logic hit;
        hit = (m.dst == w[25:21] && reads_rs(w)) || (m.dst == w[20:16] && reads_rt(w));
        return v && !b && m.valid && m.mr && m.dst != 5'd0 && hit;
    endfunction

    exp_t m;
    logic model_ok = 1'b0;

    always @(posedge clk) begin
        if (flush) begin
            m <= '0;
            model_ok <= 1'b1;
        end else if (bt || ref_stall(m, iv, ins, bt)) begin
            m <= '0;
        end else if (es) begin
            m <= m;
        end else if (!iv) begin
            m <= '0;
        end else begin
            m <= ref_id(ins, pc);
        end
    end

    // Compare everything meaningful every cycle once the model is in step.
    always @(negedge clk) begin
        if (model_ok) begin
            check("jump", jump, iv && (ins[31:26] == 6'h02 || ins[31:26] == 6'h03) && !bt);
            check("jtgt", jtgt, ins[25:0]);
            check("rsaddr", rsa, ins[25:21]);
            check("rtaddr", rta, ins[20:16]);
            check("stall", stall, ref_stall(m, iv, ins, bt));
            check("valid_id", v_id, m.valid);
            check("ctrl_id", {alu_id, rw, mr, mw, asi, br, bne, jr, lnk, ill},
                  {m.alu, m.rw, m.mr, m.mw, m.asi, m.br, m.bne, m.jr, m.lnk, m.ill});
            if (m.valid) begin
                check("pc_id", pc_id, m.pc);
                check("rs_id", rs_id, m.rs);
                check("rt_id", rt_id, m.rt);
                check("dst_id", dst_id, m.dst);
                check("imm_id", imm_id, m.imm);
                check("shamt_id", sh_id, m.shamt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] w,
                         input logic b, input logic s);
        iv  = v;
        pc  = a;
        ins = w;
        bt  = b;
        es  = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [8];
        logic [5:0] ops [11];
        logic [4:0] rs_r, rt_r, rd_r, sh_r;
        logic [15:0] im;
        int k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};
        ops = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03};
        rs_r = 5'($urandom_range(0, 3));
        rt_r = 5'($urandom_range(0, 3));
        rd_r = 5'($urandom_range(0, 3));
        sh_r = 5'($urandom);
        im   = 16'($urandom);
        k = int'($urandom_range(0, 18));
        if (k < 8) return {6'h00, rs_r, rt_r, rd_r, sh_r, fns[k]};
        return {ops[k-8], rs_r, rt_r, im};
    endfunction

    localparam logic [31:0] LwR8  = 32'h8D28_0004; // lw r8,4(r9)
    localparam logic [31:0] AddR8 = 32'h010B_5020; // add r10,r8,r11
    localparam logic [31:0] LwR0  = 32'h8D20_0004; // lw r0,4(r9)
    localparam logic [31:0] AddR0 = 32'h000B_5020; // add r10,r0,r11

    initial begin
        mre = 1'b0;
        dre = 5'd0;
        flush = 1'b1;
        drive(1'b1, 32'h0040_0000, LwR8, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_valid", v_id, 0);
        check("rst_pc", pc_id, 0);
        check("rst_regs", {rs_id, rt_id, dst_id, sh_id}, 0);
        check("rst_imm", imm_id, 0);
        check("rst_ctrl", {alu_id, rw, mr, mw, asi, br, bne, jr, lnk, ill}, 0);
        flush = 1'b0;
        tick();
        check("rst_lw_valid", v_id, 1);
        check("rst_lw_memread", mr, 1);

        // jal
        drive(1'b1, 32'h0040_0010, 32'h0C00_0040, 1'b0, 1'b0);
        #1;
        check("jal_jump", jump, 1);
        check("jal_tgt", jtgt, 32'h40);
        tick();
        check("jal_dst", dst_id, 31);
        check("jal_link", lnk, 1);
        check("jal_rw", rw, 1);
        check("jal_pc", pc_id, 32'h0040_0010);

        // load-use
        drive(1'b1, 32'h0040_0014, LwR8, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0040_0018, AddR8, 1'b0, 1'b0);
        #1;
        check("lu_stall", stall, 1);
        tick();
        check("lu_bubble", v_id, 0);
        check("lu_stall_once", stall, 0);
        tick();
        check("lu_add_valid", v_id, 1);
        check("lu_add_rs", rs_id, 8);
        check("lu_add_dst", dst_id, 10);
        drive(1'b1, 32'h0040_001C, LwR0, 1'b0, 1'b0);
        tick();
        check("lw_r0_rw", rw, 0);
        drive(1'b1, 32'h0040_0020, AddR0, 1'b0, 1'b0);
        #1;
        check("r0_no_stall", stall, 0);
        tick();
        check("r0_add_valid", v_id, 1);

        // branch squash of a held jump
        drive(1'b1, 32'h0040_0024, 32'h0800_0100, 1'b1, 1'b1);
        #1;
        check("sq_jump", jump, 0);
        tick();
        check("sq_valid", v_id, 0);

        // ExtStall hold
        drive(1'b1, 32'h0040_0028, 32'h2003_FFFF, 1'b0, 1'b0);
        tick();
        check("addi_imm", imm_id, 32'hFFFF_FFFF);
        drive(1'b1, 32'h0040_002C, 32'h3004_FFFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_imm", imm_id, 32'hFFFF_FFFF);
            check("hold_dst", dst_id, 3);
            check("hold_pc", pc_id, 32'h0040_0028);
        end
        es = 1'b0;
        tick();
        check("andi_imm", imm_id, 32'h0000_FFFF);
        check("andi_dst", dst_id, 4);

        // illegal opcode
        drive(1'b1, 32'h0040_0030, 32'hFC00_0000, 1'b0, 1'b0);
        #1;
        check("ill_jump", jump, 0);
        check("ill_stall", stall, 0);
        tick();
        check("ill_flag", ill, 1);
        check("ill_rw", rw, 0);
        check("ill_mw", mw, 0);
        check("ill_valid", v_id, 1);

        // all-zero word is a legal NOP
        drive(1'b1, 32'h0040_0034, 32'h0000_0000, 1'b0, 1'b0);
        tick();
        check("nop_legal", ill, 0);
        check("nop_rw", rw, 0);

        // randomized phase, checked by the model process
        for (int c = 0; c < 3000; c++) begin
            flush = ($urandom_range(0, 99) < 2);
            mre   = 1'($urandom);
            dre   = 5'($urandom);
            drive(($urandom_range(0, 99) < 85), $urandom, rand_instr(),
                  ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15));
            tick();
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
